alu_rs: RTL
===========

# alu_rs

Reservation station for the integer arithmetic unit: holds dispatched ALU instructions (OP, OP-IMM, LUI, AUIPC, JAL, JALR) until both source operands are available, snoops the common data bus (CDB) for pending operands, and issues the oldest ready instruction each cycle. Sits between rename/dispatch and `arith`. Its registered issue outputs drive `arith`'s `pc_i`, `inst_i`, `rs1_value_i`, `rs2_value_i` and `alu_request_i` directly.

## Interface
- `DEPTH`, 4: number of entries (2..8).
- `TAG_W`, 4: ROB tag width.
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous, active-low reset.
- `flush_i` in 1: squash all entries and the issue register.
- `disp_valid_i` in 1; `disp_ready_o` out 1: dispatch handshake.
- `disp_pc_i` in 32; `disp_inst_i` in 32; `disp_rob_tag_i` in TAG_W: instruction fields.
- `disp_rs1_ready_i` in 1; `disp_rs1_tag_i` in TAG_W; `disp_rs1_value_i` in 32: source 1 (value valid when ready).
- `disp_rs2_ready_i` in 1; `disp_rs2_tag_i` in TAG_W; `disp_rs2_value_i` in 32: source 2.
- `cdb_valid_i` in 1; `cdb_tag_i` in TAG_W; `cdb_value_i` in 32: result broadcast.
- `alu_request_o` out 1: issue valid, one cycle per instruction.
- `pc_o`, `inst_o`, `rs1_value_o`, `rs2_value_o` out 32; `rob_tag_o` out TAG_W: issued instruction.
- `count_o` out $clog2(DEPTH)+1: occupied entries.

## Operation
- Collapsing queue. Entry 0 is the oldest. Each entry holds `valid`, `pc`, `inst`, `rob_tag`, and per source `rdy`/`tag`/`value`.
- `disp_ready_o` = `count < DEPTH`, based on registered count only. There is no look-ahead on a same-cycle issue, so a full queue refuses dispatch even while issuing.
- Dispatch is accepted on `disp_valid_i && disp_ready_o`. The instruction is written at index `count` (after removal of that cycle's issued entry, if any).
- Wakeup: any valid entry with `rdy==0` and `tag==cdb_tag_i` while `cdb_valid_i` captures `cdb_value_i` and sets `rdy`. Both sources may wake on one broadcast.
- Select: the lowest-index valid entry whose registered `rdy1 && rdy2` are both set. It is removed and entries above it shift down by one. At most one issue per cycle.
- Issue register: loaded from the selected entry. `alu_request_o=0` when nothing is selected; the data outputs then hold their last values.
- `flush_i`: at the next edge, clears all `valid` bits, `count` and `alu_request_o`. Dispatch and wakeup in that cycle are discarded.
- Reset: all entries invalid. Outputs `alu_request_o=0`, `pc_o=inst_o=rs1_value_o=rs2_value_o=0`, `rob_tag_o=0`, `count_o=0`, `disp_ready_o=1`. Reset has priority over flush. Reset mid-operation drops everything.

## Timing
- Dispatch with both sources ready in cycle d: entry written at end of d, selected in d+1, `alu_request_o` high in d+2.
- CDB broadcast in cycle c wakes the last operand: captured at end of c, selected in c+1, `alu_request_o` high in c+2.
- Wakeup is never combined with selection in the same cycle.
- Shift-down and a same-cycle dispatch complete in one edge; no bubble.

## Configuration
- `ALU_RS_DISPATCH_BYPASS_EN` defined: a dispatched source with ready=0 whose tag matches a same-cycle CDB broadcast is written as ready with `cdb_value_i`.
- Undefined: it is written not-ready. Rename must then guarantee that no broadcast of that tag occurs in the dispatch cycle, otherwise the entry never wakes.

## Structure
- The shared defines/package holds `TAG_W` default, the entry struct/field layout, and the `OP_*` opcodes already used by `arith`.
- One sub-module, `alu_rs_entry`: a single entry's storage, wakeup compare and ready output, instantiated DEPTH times. Shift/select logic lives in `alu_rs`.

## Test plan
- Reset, then dispatch ADDI pc=0x100, both sources ready (rs1=5) -> `alu_request_o`=1 exactly 2 cycles later with pc_o=0x100, rs1_value_o=5, then 0.
- Dispatch A (rs1 tag 3 pending), then B (ready) -> B issues first; CDB tag 3 value 0x22 -> A issues 2 cycles after the broadcast with rs1_value_o=0x22.
- Fill 4 entries, all pending -> `disp_ready_o`=0, count_o=4; a broadcast waking entry 1 -> entry 1 issues, the others shift down, count_o=3, `disp_ready_o`=1.
- Dispatch with rs2 tag 7 not ready while CDB broadcasts tag 7 value 9 -> with the macro, issues 2 cycles later with rs2_value_o=9; without it, never issues.
- Queue holding 3 entries, `flush_i` with a simultaneous dispatch -> count_o=0 and `alu_request_o`=0 next cycle; the dispatched instruction never issues.
- Assert `reset_i`=0 while an issue is pending -> next cycle all outputs reset and count_o=0.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station: instruction payload and source operand layout.
// Opcodes match the encodings decoded by arith.
package alu_rs_pkg;

  localparam int TAG_W_DEFAULT = 4;

  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } instInfo_t;

  typedef struct packed {
    logic        rdy;
    logic [31:0] value;
  } srcVal_t;

endpackage

// File: rtl/alu_rs_entry.sv
// One reservation-station slot: holds an instruction, snoops the CDB for pending operands and
// reports when both operands are present. rs1_o/rs2_o show the operands with this cycle's wakeup applied.
module alu_rs_entry
  import alu_rs_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             valid_i,
  input  instInfo_t        info_i,
  input  logic [TAG_W-1:0] rob_tag_i,
  input  srcVal_t          rs1_i,
  input  logic [TAG_W-1:0] rs1_tag_i,
  input  srcVal_t          rs2_i,
  input  logic [TAG_W-1:0] rs2_tag_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [31:0]      cdb_value_i,
  output logic             valid_o,
  output logic             ready_o,
  output instInfo_t        info_o,
  output logic [TAG_W-1:0] rob_tag_o,
  output srcVal_t          rs1_o,
  output logic [TAG_W-1:0] rs1_tag_o,
  output srcVal_t          rs2_o,
  output logic [TAG_W-1:0] rs2_tag_o
);

  logic             valid_q;
  instInfo_t        info_q;
  logic [TAG_W-1:0] robTag_q;
  srcVal_t          rs1_q, rs1_d;
  logic [TAG_W-1:0] rs1Tag_q;
  srcVal_t          rs2_q, rs2_d;
  logic [TAG_W-1:0] rs2Tag_q;

  always_comb begin
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    if (valid_q && cdb_valid_i && !rs1_q.rdy && (cdb_tag_i == rs1Tag_q)) begin
      rs1_d = '{rdy: 1'b1, value: cdb_value_i};
    end
    if (valid_q && cdb_valid_i && !rs2_q.rdy && (cdb_tag_i == rs2Tag_q)) begin
      rs2_d = '{rdy: 1'b1, value: cdb_value_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      valid_q  <= 1'b0;
      info_q   <= '0;
      robTag_q <= '0;
      rs1_q    <= '0;
      rs1Tag_q <= '0;
      rs2_q    <= '0;
      rs2Tag_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q  <= valid_i;
      info_q   <= info_i;
      robTag_q <= rob_tag_i;
      rs1_q    <= rs1_i;
      rs1Tag_q <= rs1_tag_i;
      rs2_q    <= rs2_i;
      rs2Tag_q <= rs2_tag_i;
    end else begin
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
    end
  end

  // Readiness comes from registered flags only, so a wakeup is never selected in its own cycle.
  assign ready_o   = valid_q && rs1_q.rdy && rs2_q.rdy;
  assign valid_o   = valid_q;
  assign info_o    = info_q;
  assign rob_tag_o = robTag_q;
  assign rs1_o     = rs1_d;
  assign rs1_tag_o = rs1Tag_q;
  assign rs2_o     = rs2_d;
  assign rs2_tag_o = rs2Tag_q;

endmodule

// File: rtl/alu_rs.sv
// Collapsing-queue reservation station for the integer ALU; entry 0 is the oldest.
// Optional ALU_RS_DISPATCH_BYPASS_EN lets a dispatching operand catch a same-cycle CDB broadcast.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       disp_valid_i,
  output logic                       disp_ready_o,
  input  logic [31:0]                disp_pc_i,
  input  logic [31:0]                disp_inst_i,
  input  logic [TAG_W-1:0]           disp_rob_tag_i,
  input  logic                       disp_rs1_ready_i,
  input  logic [TAG_W-1:0]           disp_rs1_tag_i,
  input  logic [31:0]                disp_rs1_value_i,
  input  logic                       disp_rs2_ready_i,
  input  logic [TAG_W-1:0]           disp_rs2_tag_i,
  input  logic [31:0]                disp_rs2_value_i,
  input  logic                       cdb_valid_i,
  input  logic [TAG_W-1:0]           cdb_tag_i,
  input  logic [31:0]                cdb_value_i,
  output logic                       alu_request_o,
  output logic [31:0]                pc_o,
  output logic [31:0]                inst_o,
  output logic [31:0]                rs1_value_o,
  output logic [31:0]                rs2_value_o,
  output logic [TAG_W-1:0]           rob_tag_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic             entValid  [DEPTH];
  logic             entReady  [DEPTH];
  instInfo_t        entInfo   [DEPTH];
  logic [TAG_W-1:0] entRob    [DEPTH];
  srcVal_t          entRs1    [DEPTH];
  logic [TAG_W-1:0] entRs1Tag [DEPTH];
  srcVal_t          entRs2    [DEPTH];
  logic [TAG_W-1:0] entRs2Tag [DEPTH];

  logic [CW-1:0]    count_q, count_d, countAfter;
  logic             selFound;
  logic [IW-1:0]    selIdx;
  logic             dispAccept;
  logic             bypass1, bypass2;
  srcVal_t          dispRs1, dispRs2;

  logic             req_q;
  instInfo_t        issInfo_q;
  logic [31:0]      rs1Val_q, rs2Val_q;
  logic [TAG_W-1:0] robTag_q;

`ifdef ALU_RS_DISPATCH_BYPASS_EN
  assign bypass1 = !disp_rs1_ready_i && cdb_valid_i && (cdb_tag_i == disp_rs1_tag_i);
  assign bypass2 = !disp_rs2_ready_i && cdb_valid_i && (cdb_tag_i == disp_rs2_tag_i);
`else
  assign bypass1 = 1'b0;
  assign bypass2 = 1'b0;
`endif

  assign dispRs1 = bypass1 ? '{rdy: 1'b1, value: cdb_value_i}
                           : '{rdy: disp_rs1_ready_i, value: disp_rs1_value_i};
  assign dispRs2 = bypass2 ? '{rdy: 1'b1, value: cdb_value_i}
                           : '{rdy: disp_rs2_ready_i, value: disp_rs2_value_i};

  assign disp_ready_o = count_q < CW'(DEPTH);
  assign dispAccept   = disp_valid_i && disp_ready_o;

  always_comb begin
    selFound = 1'b0;
    selIdx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entReady[i]) begin
        selFound = 1'b1;
        selIdx   = IW'(i);
      end
    end
  end

  assign countAfter = count_q - CW'(selFound);
  assign count_d    = countAfter + CW'(dispAccept);

  // Each slot loads the dispatch, or its upper neighbour when at/above the issued slot, else holds.
  for (genvar g = 0; g < DEPTH; g++) begin : gEntry
    logic             load, inValid, upValid;
    instInfo_t        inInfo, upInfo;
    logic [TAG_W-1:0] inRob, inT1, inT2, upRob, upT1, upT2;
    srcVal_t          inS1, inS2, upS1, upS2;

    if (g < DEPTH - 1) begin : gUp
      assign upValid = entValid[g+1];
      assign upInfo  = entInfo[g+1];
      assign upRob   = entRob[g+1];
      assign upS1    = entRs1[g+1];
      assign upT1    = entRs1Tag[g+1];
      assign upS2    = entRs2[g+1];
      assign upT2    = entRs2Tag[g+1];
    end else begin : gTop
      assign upValid = 1'b0;
      assign upInfo  = '0;
      assign upRob   = '0;
      assign upS1    = '0;
      assign upT1    = '0;
      assign upS2    = '0;
      assign upT2    = '0;
    end

    always_comb begin
      load    = 1'b0;
      inValid = upValid;
      inInfo  = upInfo;
      inRob   = upRob;
      inS1    = upS1;
      inT1    = upT1;
      inS2    = upS2;
      inT2    = upT2;
      if (dispAccept && (CW'(g) == countAfter)) begin
        load    = 1'b1;
        inValid = 1'b1;
        inInfo  = '{pc: disp_pc_i, inst: disp_inst_i};
        inRob   = disp_rob_tag_i;
        inS1    = dispRs1;
        inT1    = disp_rs1_tag_i;
        inS2    = dispRs2;
        inT2    = disp_rs2_tag_i;
      end else if (selFound && (IW'(g) >= selIdx)) begin
        load = 1'b1;
      end
    end

    alu_rs_entry #(.TAG_W(TAG_W)) uEntry (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .flush_i    (flush_i),
      .load_i     (load),
      .valid_i    (inValid),
      .info_i     (inInfo),
      .rob_tag_i  (inRob),
      .rs1_i      (inS1),
      .rs1_tag_i  (inT1),
      .rs2_i      (inS2),
      .rs2_tag_i  (inT2),
      .cdb_valid_i(cdb_valid_i),
      .cdb_tag_i  (cdb_tag_i),
      .cdb_value_i(cdb_value_i),
      .valid_o    (entValid[g]),
      .ready_o    (entReady[g]),
      .info_o     (entInfo[g]),
      .rob_tag_o  (entRob[g]),
      .rs1_o      (entRs1[g]),
      .rs1_tag_o  (entRs1Tag[g]),
      .rs2_o      (entRs2[g]),
      .rs2_tag_o  (entRs2Tag[g])
    );
  end

  // Issue register: data holds its last value whenever nothing is selected.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      count_q   <= '0;
      req_q     <= 1'b0;
      issInfo_q <= '0;
      rs1Val_q  <= '0;
      rs2Val_q  <= '0;
      robTag_q  <= '0;
    end else if (flush_i) begin
      count_q <= '0;
      req_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      req_q   <= selFound;
      if (selFound) begin
        issInfo_q <= entInfo[selIdx];
        rs1Val_q  <= entRs1[selIdx].value;
        rs2Val_q  <= entRs2[selIdx].value;
        robTag_q  <= entRob[selIdx];
      end
    end
  end

  assign alu_request_o = req_q;
  assign pc_o          = issInfo_q.pc;
  assign inst_o        = issInfo_q.inst;
  assign rs1_value_o   = rs1Val_q;
  assign rs2_value_o   = rs2Val_q;
  assign rob_tag_o     = robTag_q;
  assign count_o       = count_q;

endmodule
